uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 148 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, WIDTH data bits LSB-first, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to insert a parity bit (par_typ: 0=even, 1=odd).
module uart_tx_serializer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] parallel_data,
    input  logic             par_typ,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PS_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [PS_W-1:0]  prescale, prescale_nxt;
    logic [BC_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0] shift, shift_nxt;
    logic             tx_nxt, busy_nxt, done_nxt;
    logic             bit_end;
    logic             par_bit, par_bit_nxt;

`ifndef UART_TX_PARITY_EN
    logic unused_par_typ;
    assign unused_par_typ = par_typ;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prescale <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            prescale <= prescale_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            par_bit  <= par_bit_nxt;
            tx_out   <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        prescale_nxt = prescale;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        par_bit_nxt  = par_bit;
        tx_nxt       = tx_out;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        bit_end      = (prescale == PS_W'(CLKS_PER_BIT - 1));

        // Every non-idle state times one serial bit with the prescaler
        if (state != IDLE) begin
            prescale_nxt = bit_end ? '0 : prescale + PS_W'(1);
        end

        case (state)
            IDLE: begin
                tx_nxt       = 1'b1;
                busy_nxt     = 1'b0;
                prescale_nxt = '0;
                bit_cnt_nxt  = '0;
                if (data_valid && !busy) begin
                    shift_nxt = parallel_data;
`ifdef UART_TX_PARITY_EN
                    par_bit_nxt = (^parallel_data) ^ par_typ;
`endif
                    state_nxt = START;
                    busy_nxt  = 1'b1;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    tx_nxt      = shift[0];
                    shift_nxt   = shift >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BC_W'(WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = par_bit;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + BC_W'(1);
                        tx_nxt      = shift[0];
                        shift_nxt   = shift >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                prescale_nxt = '0;
                bit_cnt_nxt  = '0;
                tx_nxt       = 1'b1;
                busy_nxt     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: accepted words are queued, a line monitor checks every frame cycle.
module tb_uart_tx_serializer;

    localparam int unsigned W  = 8;
    localparam int unsigned C  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = W + 3;
`else
    localparam int unsigned NB = W + 2;
`endif
    localparam time PERIOD = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         data_valid;
    logic [W-1:0] parallel_data;
    logic         par_typ;
    logic         tx_out, busy, done;

    typedef struct {
        logic [W-1:0] data;
        logic         par;
        bit           b2b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   accepted = 0;
    int   frames_seen = 0;
    time  last_done_t = 0;

    uart_tx_serializer #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .parallel_data(parallel_data),
        .par_typ(par_typ), .tx_out(tx_out), .busy(busy), .done(done)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: bit idx of the serial sequence for word e
    function automatic logic frame_bit(input exp_t e, input int idx);
        int ones = 0;
        for (int i = 0; i < int'(W); i++) ones += int'(e.data[i]);
        if (idx == 0) return 1'b0;
        if (idx <= int'(W)) return e.data[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == int'(W) + 1) return logic'(ones % 2) ^ e.par;
`endif
        return 1'b1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Drive inputs for the coming edge; a request seen with busy low is accepted there
    task automatic apply(input logic v, input logic [W-1:0] d, input logic p);
        exp_t e;
        if (v && !busy && !rst) begin
            e.data = d;
            e.par  = p;
            e.b2b  = done;
            q.push_back(e);
            accepted++;
        end
        data_valid    = v;
        parallel_data = d;
        par_typ       = p;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 2000; n++) begin
            step();
            if (!busy) begin
                apply(1'b0, W'($urandom), 1'($urandom));
                return;
            end
            apply(1'($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom));
        end
        chk(1'b0, "idle_timeout", int'(busy), 0);
    endtask

    // Line monitor: pops the scoreboard at each start bit and checks every cycle of the frame
    initial begin
        exp_t e;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (tx_out == 1'b0) begin
                frames_seen++;
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_frame", 1, 0);
                    for (int n = 0; n < 5000 && busy; n++) @(negedge clk);
                    continue;
                end
                e = q.pop_front();
                if (e.b2b) chk(($time - last_done_t) == PERIOD, "b2b_gap",
                               int'(($time - last_done_t) / PERIOD), 1);
                aborted = 1'b0;
                for (int k = 0; k < int'(NB * C); k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    chk(tx_out === frame_bit(e, k / int'(C)), "tx_bit", int'(tx_out),
                        int'(frame_bit(e, k / int'(C))));
                    chk(busy === 1'b1 && done === 1'b0, "busy_in_frame", int'({busy, done}), 2);
                end
                if (aborted) continue;
                @(negedge clk);
                if (rst) continue;
                chk(done === 1'b1 && busy === 1'b0 && tx_out === 1'b1, "frame_end",
                    int'({done, busy, tx_out}), 5);
                last_done_t = $time;
            end else begin
                chk(busy === 1'b0 && done === 1'b0, "idle_outputs", int'({busy, done}), 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        data_valid = 1'b0;
        parallel_data = '0;
        par_typ = 1'b0;
        #1;
        chk(tx_out === 1'b1 && busy === 1'b0 && done === 1'b0, "reset_values",
            int'({tx_out, busy, done}), 4);
        repeat (3) step();
        #2 rst = 1'b0;

        // Idle hold
        repeat (50) begin
            step();
            apply(1'b0, W'($urandom), 1'($urandom));
        end

        // 0xA5 with both parity types
        step(); apply(1'b1, 8'hA5, 1'b0); wait_idle();
        step(); apply(1'b1, 8'hA5, 1'b1); wait_idle();

        // Back-to-back 0x00 then 0xFF with data scrambled mid-frame
        step(); apply(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 500; n++) begin
            step();
            if (!busy) begin
                apply(1'b1, 8'hFF, 1'b1);
                break;
            end
            apply(1'b1, W'($urandom), 1'($urandom));
        end
        step(); apply(1'b0, 8'h00, 1'b0);
        wait_idle();

        // Request while busy must be dropped
        step(); apply(1'b1, 8'h55, 1'b0);
        repeat (10) begin step(); apply(1'b0, 8'h55, 1'b0); end
        step(); apply(1'b1, 8'h3C, 1'b1);
        step(); apply(1'b0, 8'h3C, 1'b1);
        wait_idle();

        // Reset during data bit 3, then a clean 0x81 frame
        step(); apply(1'b1, 8'h5A, 1'b0);
        repeat (4 * C + 2) begin step(); apply(1'b0, 8'h00, 1'b0); end
        #2 rst = 1'b1;
        #1;
        chk(tx_out === 1'b1 && busy === 1'b0 && done === 1'b0, "rst_async",
            int'({tx_out, busy, done}), 4);
        repeat (3) step();
        #2 rst = 1'b0;
        repeat (3) step();
        step(); apply(1'b1, 8'h81, 1'b0); wait_idle();

        // Randomized frames with random idle gaps
        for (int f = 0; f < 24; f++) begin
            repeat ($urandom_range(0, 3)) begin step(); apply(1'b0, W'($urandom), 1'($urandom)); end
            step(); apply(1'b1, W'($urandom), 1'($urandom));
            wait_idle();
        end

        repeat (5) step();
        chk(q.size() == 0, "queue_empty", q.size(), 0);
        chk(frames_seen == accepted, "frame_count", frames_seen, accepted);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
